// File: rtl/axi_decerr_slv.sv
// axi_decerr_slv: terminating AXI4 slave behind the demux decode-miss port.
// Every write and read is drained and completed with an error response.
package axi_decerr_slv_pkg;
    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } w_chan_t;

    typedef struct packed {
        logic [0:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } ar_chan_t;

    typedef struct packed {
        logic [0:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } axi_resp_t;
endpackage

module axi_decerr_slv #(
    parameter int unsigned AxiIdWidth  = 32'd0,
    parameter bit          AtopSupport = 1'b1,
    parameter type         axi_req_t   = axi_decerr_slv_pkg::axi_req_t,
    parameter type         axi_resp_t  = axi_decerr_slv_pkg::axi_resp_t,
    parameter logic [1:0]  Resp        = 2'b11,
    parameter logic [63:0] RespData    = 64'hCA11_AB1E_BADC_AB1E,
    parameter int unsigned MaxTrans    = 32'd4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      test_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);
    localparam int unsigned IdW  = (AxiIdWidth > 0) ? AxiIdWidth : 1;
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);
    localparam logic [CntW-1:0] Depth   = CntW'(MaxTrans);

    axi_resp_t w_resp;
    localparam int unsigned DataW = $bits(w_resp.r.data);

    function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // write job FIFO: {id, atop}
    logic [IdW:0]    r_wf_mem [MaxTrans];
    logic [PtrW-1:0] r_wf_wptr;
    logic [PtrW-1:0] r_wf_rptr;
    logic [CntW-1:0] r_wf_cnt;
    logic            w_wf_full;
    logic            w_wf_empty;
    logic            w_wf_push;
    logic            w_wf_pop;
    logic [IdW:0]    w_wf_din;
    logic [IdW:0]    w_wf_head;

    // read job FIFO: {id, len}
    logic [IdW+7:0]  r_rf_mem [MaxTrans];
    logic [PtrW-1:0] r_rf_wptr;
    logic [PtrW-1:0] r_rf_rptr;
    logic [CntW-1:0] r_rf_cnt;
    logic            w_rf_full;
    logic            w_rf_empty;
    logic            w_rf_push;
    logic            w_rf_pop;
    logic [IdW+7:0]  w_rf_din;
    logic [IdW+7:0]  w_rf_head;

    logic            r_b_full;
    logic [IdW-1:0]  r_b_id;
    logic [7:0]      r_beat_cnt;

    logic w_atop;
    logic w_aw_ready;
    logic w_aw_hs;
    logic w_ar_ready;
    logic w_ar_hs;
    logic w_w_ready;
    logic w_w_hs;
    logic w_b_hs;
    logic w_r_valid;
    logic w_r_last;
    logic w_r_hs;
    logic w_unused;

    assign w_wf_full  = (r_wf_cnt == Depth);
    assign w_wf_empty = (r_wf_cnt == '0);
    assign w_wf_head  = r_wf_mem[r_wf_rptr];
    assign w_rf_full  = (r_rf_cnt == Depth);
    assign w_rf_empty = (r_rf_cnt == '0);
    assign w_rf_head  = r_rf_mem[r_rf_rptr];

    // AR wins a read-FIFO slot over an atomic AW arriving together
    assign w_atop     = AtopSupport & slv_req_i.aw.atop[5];
    assign w_ar_ready = !w_rf_full;
    assign w_ar_hs    = slv_req_i.ar_valid & w_ar_ready;
    assign w_aw_ready = !w_wf_full
                      & !(w_atop & (w_rf_full | slv_req_i.ar_valid));
    assign w_aw_hs    = slv_req_i.aw_valid & w_aw_ready;

    assign w_wf_push = w_aw_hs;
    assign w_wf_din  = {slv_req_i.aw.id, w_atop};
    assign w_rf_push = w_ar_hs | (w_aw_hs & w_atop);
    assign w_rf_din  = w_ar_hs ? {slv_req_i.ar.id, slv_req_i.ar.len}
                               : {slv_req_i.aw.id, 8'd0};

    assign w_w_ready = !w_wf_empty & !r_b_full;
    assign w_w_hs    = slv_req_i.w_valid & w_w_ready;
    assign w_wf_pop  = w_w_hs & slv_req_i.w.last;
    assign w_b_hs    = r_b_full & slv_req_i.b_ready;

    assign w_r_valid = !w_rf_empty;
    assign w_r_last  = (r_beat_cnt == w_rf_head[7:0]);
    assign w_r_hs    = w_r_valid & slv_req_i.r_ready;
    assign w_rf_pop  = w_r_hs & w_r_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wf_wptr <= '0;
            r_wf_rptr <= '0;
            r_wf_cnt  <= '0;
            for (int unsigned i = 0; i < MaxTrans; i++) begin
                r_wf_mem[i] <= '0;
            end
        end else begin
            if (w_wf_push) begin
                r_wf_mem[r_wf_wptr] <= w_wf_din;
                r_wf_wptr           <= f_inc(r_wf_wptr);
            end
            if (w_wf_pop) begin
                r_wf_rptr <= f_inc(r_wf_rptr);
            end
            if (w_wf_push && !w_wf_pop) begin
                r_wf_cnt <= r_wf_cnt + 1'b1;
            end else if (!w_wf_push && w_wf_pop) begin
                r_wf_cnt <= r_wf_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rf_wptr <= '0;
            r_rf_rptr <= '0;
            r_rf_cnt  <= '0;
            for (int unsigned i = 0; i < MaxTrans; i++) begin
                r_rf_mem[i] <= '0;
            end
        end else begin
            if (w_rf_push) begin
                r_rf_mem[r_rf_wptr] <= w_rf_din;
                r_rf_wptr           <= f_inc(r_rf_wptr);
            end
            if (w_rf_pop) begin
                r_rf_rptr <= f_inc(r_rf_rptr);
            end
            if (w_rf_push && !w_rf_pop) begin
                r_rf_cnt <= r_rf_cnt + 1'b1;
            end else if (!w_rf_push && w_rf_pop) begin
                r_rf_cnt <= r_rf_cnt - 1'b1;
            end
        end
    end

    // single B slot; it also gates w_ready so only one B is in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_b_full <= 1'b0;
            r_b_id   <= '0;
        end else if (w_wf_pop) begin
            r_b_full <= 1'b1;
            r_b_id   <= w_wf_head[IdW:1];
        end else if (w_b_hs) begin
            r_b_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beat_cnt <= '0;
        end else if (w_r_hs) begin
            r_beat_cnt <= w_r_last ? 8'd0 : r_beat_cnt + 8'd1;
        end
    end

    always_comb begin
        w_resp          = '0;
        w_resp.aw_ready = w_aw_ready;
        w_resp.w_ready  = w_w_ready;
        w_resp.b_valid  = r_b_full;
        w_resp.b.id     = r_b_id;
        w_resp.b.resp   = Resp;
        w_resp.ar_ready = w_ar_ready;
        w_resp.r_valid  = w_r_valid;
        w_resp.r.id     = w_rf_head[IdW+7:8];
        w_resp.r.data   = RespData[DataW-1:0];
        w_resp.r.resp   = Resp;
        w_resp.r.last   = w_r_last;
    end

    assign slv_resp_o = w_resp;

    assign w_unused = ^{test_i, slv_req_i, w_wf_head[0]};

    a_w_after_aw: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slv_req_i.w_valid & w_w_ready) |-> !w_wf_empty);

    a_b_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_b_full & !slv_req_i.b_ready)
        |=> (r_b_full && $stable(r_b_id)));

    a_r_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_r_valid & !slv_req_i.r_ready)
        |=> (w_r_valid && $stable(slv_resp_o.r)));
endmodule

// File: tb/tb_axi_decerr_slv.sv
// tb_axi_decerr_slv: directed bench for the decode-error slave.
// Expected B/R beats are queued at issue; a monitor checks each handshake.
`timescale 1ns/1ps
module tb_axi_decerr_slv;
    localparam int unsigned IdW = 4;
    localparam logic [63:0] ExpData = 64'hCA11_AB1E_BADC_AB1E;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [31:0]    addr;
        logic [7:0]     len;
        logic [5:0]     atop;
        logic [0:0]     user;
    } aw_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } w_t;
    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
        logic [0:0]     user;
    } b_t;
    typedef struct packed {
        logic [IdW-1:0] id;
        logic [31:0]    addr;
        logic [7:0]     len;
        logic [0:0]     user;
    } ar_t;
    typedef struct packed {
        logic [IdW-1:0] id;
        logic [63:0]    data;
        logic [1:0]     resp;
        logic           last;
        logic [0:0]     user;
    } r_t;
    typedef struct packed {
        aw_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ar_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        logic ar_ready;
        r_t   r;
        logic r_valid;
    } resp_t;
    typedef struct packed {
        logic [IdW-1:0] id;
        logic           last;
    } rexp_t;

    logic  clk;
    logic  rst_n;
    req_t  req;
    resp_t resp;

    int checks;
    int errors;

    logic [IdW-1:0] b_exp[$];
    rexp_t          r_exp[$];

    axi_decerr_slv #(
        .AxiIdWidth (IdW),
        .AtopSupport(1'b1),
        .axi_req_t  (req_t),
        .axi_resp_t (resp_t),
        .MaxTrans   (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .test_i    (1'b0),
        .slv_req_i (req),
        .slv_resp_o(resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [IdW-1:0] m_bid;
    rexp_t          m_r;

    always @(negedge clk) begin
        if (rst_n) begin
            if (resp.b_valid && req.b_ready) begin
                if (b_exp.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    m_bid = b_exp.pop_front();
                    check("b_id", resp.b.id, m_bid);
                    check("b_resp", resp.b.resp, 2'b11);
                    check("b_user", resp.b.user, 0);
                end
            end
            if (resp.r_valid && req.r_ready) begin
                if (r_exp.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    m_r = r_exp.pop_front();
                    check("r_id", resp.r.id, m_r.id);
                    check("r_data", resp.r.data, ExpData);
                    check("r_resp", resp.r.resp, 2'b11);
                    check("r_last", resp.r.last, m_r.last);
                    check("r_user", resp.r.user, 0);
                end
            end
        end
    end

    task automatic do_aw(input logic [IdW-1:0] id, input logic [5:0] atop);
        int t;
        t = 0;
        req.aw      = '0;
        req.aw.id   = id;
        req.aw.len  = 8'd3;
        req.aw.atop = atop;
        req.aw_valid = 1'b1;
        @(negedge clk);
        while (!resp.aw_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!resp.aw_ready) check("aw_timeout", 1, 0);
        @(posedge clk);
        #1;
        req.aw_valid = 1'b0;
    endtask

    task automatic do_w(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            req.w      = '0;
            req.w.data = {$urandom, $urandom};
            req.w.strb = '1;
            req.w.last = (i == n - 1);
            req.w_valid = 1'b1;
            @(negedge clk);
            while (!resp.w_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!resp.w_ready) check("w_timeout", 1, 0);
            @(posedge clk);
            #1;
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
    endtask

    task automatic do_ar(input logic [IdW-1:0] id, input logic [7:0] len);
        int t;
        t = 0;
        for (int k = 0; k <= int'(len); k++) begin
            r_exp.push_back(rexp_t'{id, (k == int'(len))});
        end
        req.ar     = '0;
        req.ar.id  = id;
        req.ar.len = len;
        req.ar_valid = 1'b1;
        @(negedge clk);
        while (!resp.ar_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!resp.ar_ready) check("ar_timeout", 1, 0);
        @(posedge clk);
        #1;
        req.ar_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((b_exp.size() != 0 || r_exp.size() != 0) && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_timeout", (b_exp.size() != 0 || r_exp.size() != 0), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_aw_ready"}, resp.aw_ready, 1);
        check({tag, "_ar_ready"}, resp.ar_ready, 1);
        check({tag, "_w_ready"}, resp.w_ready, 0);
        check({tag, "_b_valid"}, resp.b_valid, 0);
        check({tag, "_r_valid"}, resp.r_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        checks = 0;
        errors = 0;
        req = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single write, id 5, four beats
        b_exp.push_back(4'd5);
        do_aw(4'd5, 6'd0);
        check("w_ready_after_aw", resp.w_ready, 1);
        do_w(4);
        check("b_valid_after_wlast", resp.b_valid, 1);
        drain(50);
        check("b_valid_cleared", resp.b_valid, 0);
        check("w_ready_idle", resp.w_ready, 0);

        // read burst, then again with r_ready toggling
        do_ar(4'd3, 8'd7);
        drain(100);
        fork
            do_ar(4'd3, 8'd7);
            begin
                for (int i = 0; i < 40; i++) begin
                    req.r_ready = ~req.r_ready;
                    @(posedge clk);
                    #1;
                end
                req.r_ready = 1'b1;
            end
        join
        drain(100);
        check("r_valid_idle", resp.r_valid, 0);

        // write FIFO full
        for (int i = 1; i <= 4; i++) begin
            b_exp.push_back(IdW'(i));
            do_aw(IdW'(i), 6'd0);
        end
        check("aw_ready_full", resp.aw_ready, 0);
        b_exp.push_back(4'd10);
        fork
            do_aw(4'd10, 6'd0);
            begin
                repeat (3) @(negedge clk);
                check("aw_stall_full", resp.aw_ready, 0);
                @(posedge clk);
                #1;
                do_w(2);
            end
        join
        for (int i = 0; i < 4; i++) do_w(2);
        drain(100);

        // B backpressure with a second AW queued
        req.b_ready = 1'b0;
        b_exp.push_back(4'd7);
        do_aw(4'd7, 6'd0);
        b_exp.push_back(4'd8);
        do_aw(4'd8, 6'd0);
        do_w(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_b_valid", resp.b_valid, 1);
            check("bp_b_id", resp.b.id, 4'd7);
            check("bp_w_ready", resp.w_ready, 0);
        end
        @(posedge clk);
        #1;
        req.b_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("w_ready_resume", resp.w_ready, 1);
        @(posedge clk);
        #1;
        do_w(3);
        drain(50);

        // atomic AW colliding with AR
        r_exp.push_back(rexp_t'{4'd2, 1'b1});
        r_exp.push_back(rexp_t'{4'd9, 1'b1});
        b_exp.push_back(4'd9);
        req.aw      = '0;
        req.aw.id   = 4'd9;
        req.aw.atop = 6'b100000;
        req.aw_valid = 1'b1;
        req.ar      = '0;
        req.ar.id   = 4'd2;
        req.ar.len  = 8'd0;
        req.ar_valid = 1'b1;
        @(negedge clk);
        check("atop_ar_ready", resp.ar_ready, 1);
        check("atop_aw_yield", resp.aw_ready, 0);
        @(posedge clk);
        #1;
        req.ar_valid = 1'b0;
        @(negedge clk);
        check("atop_aw_next", resp.aw_ready, 1);
        @(posedge clk);
        #1;
        req.aw_valid = 1'b0;
        do_w(1);
        drain(50);

        // reset in the middle of a 16-beat read
        do_ar(4'd4, 8'd15);
        t = 0;
        while (r_exp.size() > 13 && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("midrst_progress", r_exp.size(), 13);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        r_exp.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_r", resp.r_valid, 0);
        end
        @(posedge clk);
        #1;
        do_ar(4'd6, 8'd0);
        drain(50);
        repeat (3) begin
            @(negedge clk);
            check("single_beat_only", resp.r_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
